// File: rtl/eac_select_pipe.sv
// One's-complement end-around-carry adder back end: registers a bundle of
// carry-select group sums, resolves the end-around carry and selects per group.

module eac_grp_sel #(
    parameter int GW = 4
) (
    input  logic          cs,
    input  logic [GW-1:0] s,
    input  logic [GW-1:0] s1,
    output logic [GW-1:0] sel
);
    assign sel = cs ? s1 : s;
endmodule

module eac_select_pipe #(
    parameter int CLA_GRP_WIDTH = 4,
    parameter int NUM_GRPS      = 4,
    parameter int W             = CLA_GRP_WIDTH * NUM_GRPS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    grp_s,
    input  logic [W-1:0]    grp_s1,
    input  logic [NUM_GRPS-1:0] grp_gg,
    input  logic [NUM_GRPS-1:0] grp_gp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    sum,
    output logic            eac,
    output logic            neg_zero
);
    // S1 bundle
    logic                s1_valid;
    logic [W-1:0]        s1_s;
    logic [W-1:0]        s1_s1;
    logic [NUM_GRPS-1:0] s1_gg;
    logic [NUM_GRPS-1:0] s1_gp;

    logic in_fire;
    logic s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_s1    <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_s     <= grp_s;
                s1_s1    <= grp_s1;
                s1_gg    <= grp_gg;
                s1_gp    <= grp_gp;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Two independent chains: the first (carry-in 0) yields the wrap carry,
    // the second re-runs with it as carry-in, so no combinational loop exists.
    logic [NUM_GRPS:0]   c;
    logic [NUM_GRPS-1:0] cs;
    logic                eac_nxt;
    logic                nz_nxt;
    logic [W-1:0]        sum_nxt;

    always_comb begin
        c    = '0;
        c[0] = 1'b0;
        for (int k = 0; k < NUM_GRPS; k++) begin
            c[k+1] = s1_gg[k] | (s1_gp[k] & c[k]);
        end
    end

    assign eac_nxt = c[NUM_GRPS];
    assign nz_nxt  = &s1_gp;

    always_comb begin
        cs    = '0;
        cs[0] = eac_nxt;
        for (int k = 0; k < NUM_GRPS - 1; k++) begin
            cs[k+1] = s1_gg[k] | (s1_gp[k] & cs[k]);
        end
    end

    eac_grp_sel #(.GW(CLA_GRP_WIDTH)) u_sel [NUM_GRPS-1:0] (
        .cs  (cs),
        .s   (s1_s),
        .s1  (s1_s1),
        .sel (sum_nxt)
    );

    // S2: result registers only change when a valid bundle moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            eac       <= 1'b0;
            neg_zero  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum      <= sum_nxt;
                eac      <= eac_nxt;
                neg_zero <= nz_nxt;
            end
        end
    end
endmodule

// File: doc/eac_select_pipe.md
EAC_SELECT_PIPE -- requirements
Module: eac_select_pipe

Interface
REQ-001 Parameter CLA_GRP_WIDTH, default 4, width of one CLA group in bits.
REQ-002 Parameter NUM_GRPS, default 4, number of groups; word width W = CLA_GRP_WIDTH*NUM_GRPS.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  group-result bundle valid.
REQ-007 in_ready  output  1  block can accept a bundle this cycle.
REQ-008 grp_s  input  W  concatenated per-group sums assuming carry-in 0 (group k at bits [k*CLA_GRP_WIDTH +: CLA_GRP_WIDTH]).
REQ-009 grp_s1  input  W  concatenated per-group sums assuming carry-in 1.
REQ-010 grp_gg  input  NUM_GRPS  per-group generate.
REQ-011 grp_gp  input  NUM_GRPS  per-group propagate.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 sum  output  W  one's-complement end-around-carry sum.
REQ-015 eac  output  1  end-around carry that was applied.
REQ-016 neg_zero  output  1  all groups propagate: sum is all-ones, one's-complement negative zero.

Function
REQ-017 Two register stages: S1 captures the input bundle; S2 holds the selected result. Minimum latency is 2 cycles from input acceptance to out_valid.
REQ-018 The input transfer SHALL occur when in_valid && in_ready.
REQ-019 S2 loads when !out_valid || out_ready (s2_load).
REQ-020 in_ready = !s1_valid || s2_load, evaluated combinationally from current state and out_ready.
REQ-021 s1_valid is set on input transfer and cleared when S2 loads without a new transfer.
REQ-022 When S2 loads, out_valid takes s1_valid.
REQ-023 The output registers SHALL hold their value while out_valid && !out_ready; no bundle is dropped or duplicated.
REQ-024 Simultaneous input transfer and S2 load: S1 passes its bundle to S2 and captures the new bundle in the same cycle, giving one bundle per cycle throughput.
REQ-025 eac = group-carry chain over grp_gg/grp_gp from the registered S1 bundle with carry 0 into group 0: c[k+1] = gg[k] | (gp[k] & c[k]), and eac = c[NUM_GRPS].
REQ-026 Group carries for selection: cs[0] = eac; cs[k+1] = gg[k] | (gp[k] & cs[k]).
REQ-027 Sum group k = cs[k] ? grp_s1 group k : grp_s group k.
REQ-028 neg_zero = &gp.
REQ-029 When neg_zero=1, eac=0 and the all-ones result SHALL be passed through unmodified; no wrap loop is formed.
REQ-030 The carry logic SHALL be purely combinational between S1 and S2, with no combinational path from input data to outputs.
REQ-031 sum, eac and neg_zero SHALL be registered in S2 only.

Reset
REQ-032 On rst_n low, s1_valid=0, out_valid=0, sum=0, eac=0 and neg_zero=0 immediately, without waiting for a clock edge.
REQ-033 In-flight bundles are discarded on reset.
REQ-034 in_ready=1 while in reset and on the first cycle after reset.
REQ-035 After rst_n rises, the first accepted bundle SHALL appear 2 cycles later.

Verification
(W=16, groups produced by a reference CLA-group model from operands a, b.)
REQ-036 a=0x1234, b=0x0001, out_ready=1 -> 2 cycles later sum=0x1235, eac=0, neg_zero=0.
REQ-037 a=0x8000, b=0x8000 -> sum=0x0001, eac=1; also a=0x00FF, b=0xFF01 -> sum=0x0001, eac=1 (carry ripples through group 1).
REQ-038 a=0x5555, b=0xAAAA -> sum=0xFFFF, eac=0, neg_zero=1.
REQ-039 Back-to-back stream of 8 bundles with out_ready=1 -> 8 results in order, one per cycle, in_ready constantly 1.
REQ-040 out_ready held 0 for 3 cycles with a continuous stream -> sum stable while stalled, in_ready drops after S1 fills, no loss or duplication on release.
REQ-041 rst_n pulsed low while both stages valid -> out_valid=0 and sum=0 immediately; the next bundle produces a correct result after 2 cycles.
